lsu_mem_if: RTL and testbench
=============================

# lsu_mem_if

Sequential load/store unit placed between the execute stage and the data-memory port. It accepts one load/store request at a time over a valid/ready handshake and drives a word-addressed memory bus with byte enables and a multi-cycle acknowledge. It returns formatted, sign- or zero-extended load data with an error flag. It adds byte-lane steering, misalignment detection and a bus timeout.

## Interface

Parameters:
- ADDR_W, 32: address width. Must be ≥ 3.
- TIMEOUT, 255: maximum number of cycles `mem_req` may stay high without `mem_ack`. 0 disables the timeout.
- TO_W, 8: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request. High only in IDLE.
- op_code  in  3  operation. Encodings: LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7.
- addr  in  ADDR_W  byte address.
- wr_data  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse marking a completed request.
- rd_data  out  32  formatted load result. Forced to 0 for stores and errors.
- err  out  1  qualified by `resp_valid`: 1 = misaligned access or timeout.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  1 = write.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}.
- mem_wr_data  out  32  lane-replicated store data.
- mem_rd_data  in  32  read data, valid in the cycle `mem_ack` is high.
- mem_ack  in  1  memory completion. Sampled only while `mem_req` is high.

## Operation

- The FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, register `op_code`, `addr` and `wr_data`.
  - If the access is misaligned and LSU_MISALIGN_TRAP_EN is defined, go to RESP with err=1.
  - Otherwise go to BUS.
- BUS:
  - `mem_req` = 1.
  - `mem_we`, `mem_be`, `mem_addr` and `mem_wr_data` are driven from the registered request and stay stable throughout BUS.
  - On `mem_ack`, capture the formatted data and go to RESP with err=0.
  - If TIMEOUT ≠ 0 and the counter reaches TIMEOUT without `mem_ack`, go to RESP with err=1.
  - The counter clears on entry to BUS.
- RESP:
  - `resp_valid` = 1 for exactly one cycle, then return to IDLE.
  - No request is accepted in this cycle.
- Byte enables and write data, with o = addr[1:0]:
  - SB: `mem_be` = 4'b0001 << o; `mem_wr_data` = {4{wr_data[7:0]}}.
  - SH: `mem_be` = 4'b0011 << (2·o[1]); `mem_wr_data` = {2{wr_data[15:0]}}.
  - SW: `mem_be` = 4'hF; `mem_wr_data` = wr_data.
  - Loads: `mem_be` = 4'hF; `mem_we` = 0.
- Load formatting:
  - Shift: s = mem_rd_data >> (8·o) for byte loads, mem_rd_data >> (16·o[1]) for halfword loads, no shift for LW.
  - LB and LH sign-extend bit 7 and bit 15 of s respectively.
  - LBU and LHU zero-extend.
  - LW returns the full word.
- Misalignment definition: LH, LHU or SH with addr[0]=1; LW or SW with addr[1:0]≠0. Byte accesses are never misaligned.
- A misaligned access never asserts `mem_req`.
- A timeout drops `mem_req`. A `mem_ack` arriving afterwards is ignored.

## Timing

- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `err`=0, `rd_data`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wr_data`=0, timeout counter 0.
- Reset asserted mid-transaction:
  - `mem_req` drops and state goes to IDLE immediately, asynchronously.
  - No `resp_valid` is generated for the aborted request.
- Accept edge is cycle 0, so `mem_req` is high in cycle 1. If `mem_ack` is high in cycle k (k ≥ 1), `resp_valid` is high in cycle k+1.
- Minimum latency is 2 cycles, i.e. 3 cycles from accept back to `req_ready` high.
- Misaligned trap: `resp_valid` is high in cycle 1.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, and `resp_valid` (err=1) is high in cycle TIMEOUT+1.
- `mem_ack` in the same cycle the counter reaches TIMEOUT: the ack wins and err=0.
- All outputs are registered. There is no combinational path from `mem_ack` to any output.

## Configuration

- LSU_MISALIGN_TRAP_EN defined: misaligned requests complete with err=1 and no bus cycle, as specified above.
- LSU_MISALIGN_TRAP_EN not defined:
  - Misalignment detection is removed and `err` is driven only by timeout.
  - Misaligned requests are forced to natural alignment: halfword accesses ignore addr[0]; word accesses ignore addr[1:0].

## Test plan

- LB at addr 0x103, `mem_rd_data`=0x80FF_1234, ack in cycle 1 → `mem_be`=4'hF, `mem_addr`=0x100, `rd_data`=0xFFFF_FF80, err=0, `resp_valid` in cycle 2.
- SH at addr 0x22, `wr_data`=0xDEAD_BEEF, ack after 3 wait cycles → `mem_be`=4'b1100, `mem_wr_data`=0xBEEF_BEEF, `mem_we`=1, `resp_valid` in cycle 5, `rd_data`=0.
- LHU at 0x2, `mem_rd_data`=0x8001_0000 → `rd_data`=0x0000_8001. LH at the same address and data → `rd_data`=0xFFFF_8001.
- LW at 0x6 with macro defined → no `mem_req`, `resp_valid` in cycle 1 with err=1. Without the macro → `mem_addr`=0x4, normal LW completion.
- TIMEOUT=4, no ack → `mem_req` high for cycles 1–4, `resp_valid` with err=1 in cycle 5. A late `mem_ack` in cycle 6 causes no effect.
- Reset pulse in cycle 2 of a pending SW → `mem_req`=0 immediately, no `resp_valid`, `req_ready`=1 after reset release, and the next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Sequential load/store unit between execute and a word-addressed data-memory bus.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_if #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        op_code,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  output logic              resp_valid,
  output logic [31:0]       rd_data,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_ack
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [1:0]      off_q;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            mis;
  logic            half_op;
  logic            word_op;
  logic [1:0]      off_in;

  function automatic logic [3:0] be_of(input logic [2:0] op, input logic [1:0] o);
    case (op)
      OP_SB:   be_of = 4'b0001 << o;
      OP_SH:   be_of = 4'b0011 << {o[1], 1'b0};
      default: be_of = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wd_of(input logic [2:0] op, input logic [31:0] wd);
    case (op)
      OP_SB:   wd_of = {4{wd[7:0]}};
      OP_SH:   wd_of = {2{wd[15:0]}};
      default: wd_of = wd;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [2:0] op, input logic [1:0] o,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{o, 3'b000} +: 8];
    h = d[{o[1], 4'b0000} +: 16];
    case (op)
      OP_LB:   fmt_load = {{24{b[7]}}, b};
      OP_LH:   fmt_load = {{16{h[15]}}, h};
      OP_LBU:  fmt_load = {24'b0, b};
      OP_LHU:  fmt_load = {16'b0, h};
      OP_LW:   fmt_load = d;
      default: fmt_load = 32'b0;
    endcase
  endfunction

  assign half_op = (op_code == OP_LH) || (op_code == OP_LHU) || (op_code == OP_SH);
  assign word_op = (op_code == OP_LW) || (op_code == OP_SW);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis    = (half_op && addr[0]) || (word_op && (addr[1:0] != 2'b00));
  assign off_in = addr[1:0];
`else
  // Without the trap, misaligned requests are snapped to natural alignment.
  assign mis    = 1'b0;
  assign off_in = word_op ? 2'b00 : (half_op ? {addr[1], 1'b0} : addr[1:0]);
`endif

  generate
    if (TIMEOUT != 0) begin : g_to
      assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));
    end else begin : g_no_to
      assign to_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= '0;
      off_q       <= '0;
      to_cnt      <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      rd_data     <= '0;
      err         <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= op_code;
            off_q     <= off_in;
            req_ready <= 1'b0;
            if (mis) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              err        <= 1'b1;
              rd_data    <= '0;
            end else begin
              state       <= BUS;
              to_cnt      <= '0;
              mem_req     <= 1'b1;
              mem_we      <= (op_code >= OP_SB);
              mem_be      <= be_of(op_code, off_in);
              mem_addr    <= {addr[ADDR_W-1:2], 2'b00};
              mem_wr_data <= wd_of(op_code, wr_data);
            end
          end
        end
        BUS: begin
          // An ack in the terminal-count cycle takes priority over the timeout.
          if (mem_ack) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            err        <= 1'b0;
            rd_data    <= (op_q >= OP_SB) ? 32'b0 : fmt_load(op_q, off_q, mem_rd_data);
          end else if (to_hit) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            err        <= 1'b1;
            rd_data    <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          err        <= 1'b0;
          rd_data    <= '0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if: cycle-timeline model plus literal spot checks.
// Works with or without LSU_MISALIGN_TRAP_EN defined.
module tb_lsu_mem_if;
  localparam int TMO = 4;
  localparam int NC  = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op_code;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        resp_valid;
  logic [31:0] rd_data;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        mem_ack;

  lsu_mem_if #(.ADDR_W(32), .TIMEOUT(TMO), .TO_W(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op_code(op_code), .addr(addr), .wr_data(wr_data), .resp_valid(resp_valid),
    .rd_data(rd_data), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // expected per-cycle timeline, indexed by cycle number
  bit          exp_ready [NC];
  bit          exp_req   [NC];
  bit          exp_resp  [NC];
  bit          exp_err   [NC];
  bit          exp_we    [NC];
  logic [3:0]  exp_be    [NC];
  logic [31:0] exp_addr  [NC];
  logic [31:0] exp_wd    [NC];
  logic [31:0] exp_rd    [NC];

  int          ack_cyc = -1;
  logic [31:0] ack_data = '0;
  int          last_a;

  logic [31:0] cap_be, cap_addr, cap_wd, cap_rd;
  logic        cap_we, cap_err;
  int          req_cnt, resp_rel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): actual 0x%08h required 0x%08h", nm, cyc, act, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] op);
    case (op)
      3'd0, 3'd3, 3'd5: return 1;
      3'd1, 3'd4, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  // gather the accessed bytes, then extend arithmetically
  function automatic logic [31:0] m_load(input logic [2:0] op, input int lo, input logic [31:0] d);
    int s;
    longint v;
    s = sz(op);
    v = 0;
    for (int j = 0; j < s; j++)
      v = v | (longint'((d >> (8 * (lo + j))) & 32'hFF) << (8 * j));
    if ((op == 3'd0 || op == 3'd1) && (((v >> (8 * s - 1)) & 1) == 1))
      v = v - (longint'(1) << (8 * s));
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_be(input bit st, input int lo, input int s);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = st ? ((i >= lo) && (i < lo + s)) : 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] wd, input int s);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % s) +: 8];
    return w;
  endfunction

  task automatic set_idle(input int c);
    exp_ready[c] = 1; exp_req[c] = 0; exp_resp[c] = 0; exp_err[c] = 0;
  endtask

  // called at a negedge with the DUT idle; returns at the negedge after the accept edge
  task automatic start_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int k);
    int  ca, s, o, lo, m;
    bit  st, trap, tmo;
    ca = cyc; last_a = ca;
    s  = sz(op);
    o  = int'(a[1:0]);
    lo = o - (o % s);
    st = (op >= 3'd5);
    trap = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (o % s) != 0;
`endif
    if (trap) begin
      exp_ready[ca+1] = 0; exp_resp[ca+1] = 1; exp_err[ca+1] = 1; exp_rd[ca+1] = 0;
    end else begin
      tmo = !(k >= 1 && k <= TMO);
      m   = tmo ? TMO : k;
      for (int c = ca + 1; c <= ca + m; c++) begin
        exp_ready[c] = 0; exp_req[c] = 1; exp_we[c] = st;
        exp_be[c] = m_be(st, lo, s); exp_addr[c] = a & ~32'h3; exp_wd[c] = m_wd(wd, s);
      end
      exp_ready[ca+m+1] = 0; exp_resp[ca+m+1] = 1; exp_err[ca+m+1] = tmo;
      exp_rd[ca+m+1] = (st || tmo) ? 32'h0 : m_load(op, lo, rdat);
    end
    ack_cyc  = (k >= 1) ? ca + k : -1;
    ack_data = rdat;
    req_valid = 1'b1; op_code = op; addr = a; wr_data = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int k);
    bit seen;
    start_txn(op, a, wd, rdat, k);
    req_cnt = 0; resp_rel = 0; seen = 0;
    for (int r = 1; r <= 40 && !seen; r++) begin
      if (r > 1) @(negedge clk);
      if (mem_req) begin
        if (req_cnt == 0) begin
          cap_be = {28'b0, mem_be}; cap_addr = mem_addr; cap_wd = mem_wr_data; cap_we = mem_we;
        end
        req_cnt++;
      end
      if (resp_valid) begin
        seen = 1; resp_rel = r; cap_rd = rd_data; cap_err = err;
      end
    end
    if (!seen) chk("resp_budget", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // memory responder
  initial forever begin
    @(negedge clk);
    mem_ack     = (cyc == ack_cyc);
    mem_rd_data = (cyc == ack_cyc) ? ack_data : 32'hA5A5_5A5A;
  end

  // per-cycle compare against the timeline model
  initial forever begin
    @(negedge clk);
    if (cyc < NC) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready[cyc]});
      chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req[cyc]});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_resp[cyc]});
      if (exp_resp[cyc]) begin
        chk("err", {31'b0, err}, {31'b0, exp_err[cyc]});
        chk("rd_data", rd_data, exp_rd[cyc]);
      end
      if (exp_req[cyc]) begin
        chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we[cyc]});
        chk("mem_be", {28'b0, mem_be}, {28'b0, exp_be[cyc]});
        chk("mem_addr", mem_addr, exp_addr[cyc]);
        if (exp_we[cyc]) chk("mem_wr_data", mem_wr_data, exp_wd[cyc]);
      end
    end
  end

  initial begin
    for (int c = 0; c < NC; c++) set_idle(c);
    reset = 1'b1; req_valid = 1'b0; op_code = '0; addr = '0; wr_data = '0;
    mem_ack = 1'b0; mem_rd_data = '0;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp", {31'b0, resp_valid}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_be", {28'b0, mem_be}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wd", mem_wr_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_txn(3'd0, 32'h103, 32'h0, 32'h80FF_1234, 1);
    chk("lb_be", cap_be, 32'hF);
    chk("lb_addr", cap_addr, 32'h100);
    chk("lb_rd", cap_rd, 32'hFFFF_FF80);
    chk("lb_err", {31'b0, cap_err}, 32'd0);
    chk("lb_lat", resp_rel, 2);

    run_txn(3'd6, 32'h22, 32'hDEAD_BEEF, 32'h0, 4);
    chk("sh_be", cap_be, 32'hC);
    chk("sh_wd", cap_wd, 32'hBEEF_BEEF);
    chk("sh_we", {31'b0, cap_we}, 32'd1);
    chk("sh_lat", resp_rel, 5);
    chk("sh_rd", cap_rd, 32'd0);
    chk("sh_err", {31'b0, cap_err}, 32'd0);

    run_txn(3'd4, 32'h2, 32'h0, 32'h8001_0000, 1);
    chk("lhu_rd", cap_rd, 32'h0000_8001);
    run_txn(3'd1, 32'h2, 32'h0, 32'h8001_0000, 2);
    chk("lh_rd", cap_rd, 32'hFFFF_8001);

    run_txn(3'd2, 32'h6, 32'h0, 32'h1234_5678, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_req", req_cnt, 0);
    chk("lw_mis_lat", resp_rel, 1);
    chk("lw_mis_err", {31'b0, cap_err}, 32'd1);
`else
    chk("lw_mis_addr", cap_addr, 32'h4);
    chk("lw_mis_rd", cap_rd, 32'h1234_5678);
    chk("lw_mis_err", {31'b0, cap_err}, 32'd0);
`endif

    // timeout with a late ack in cycle 6
    run_txn(3'd2, 32'h10, 32'h0, 32'h5555_AAAA, 6);
    chk("to_req_cycles", req_cnt, TMO);
    chk("to_lat", resp_rel, TMO + 1);
    chk("to_err", {31'b0, cap_err}, 32'd1);
    repeat (3) @(negedge clk);

    run_txn(3'd5, 32'h3, 32'h0000_005A, 32'h0, 2);
    chk("sb_be", cap_be, 32'h8);
    chk("sb_wd", cap_wd, 32'h5A5A_5A5A);
    run_txn(3'd3, 32'h1, 32'h0, 32'h0000_8000, 3);
    chk("lbu_rd", cap_rd, 32'h0000_0080);
    run_txn(3'd7, 32'h8, 32'h0102_0304, 32'h0, 3);
    chk("sw_wd", cap_wd, 32'h0102_0304);
    run_txn(3'd1, 32'h5, 32'h0, 32'hC0DE_8765, 1);
    run_txn(3'd6, 32'h31, 32'h0000_1234, 32'h0, 2);

    // reset pulse in cycle 2 of a pending SW
    start_txn(3'd7, 32'h40, 32'h1122_3344, 32'h0, 0);
    for (int c = last_a + 2; c <= last_a + TMO + 3; c++) set_idle(c);
    chk("sw_req_before_rst", {31'b0, mem_req}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_req", {31'b0, mem_req}, 32'd0);
    chk("rst_async_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_async_resp", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    run_txn(3'd2, 32'h20, 32'h0, 32'hCAFE_F00D, 1);
    chk("post_rst_rd", cap_rd, 32'hCAFE_F00D);
    chk("post_rst_lat", resp_rel, 2);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_time_limit: actual timeout required completion");
    $fatal(1, "time limit");
  end

endmodule
